// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between the data cache and the data memory port.
// Define WB_FWD_EN to return full-word pending store data to hazarding reads.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          UP_CSN,
    input  logic          UP_WEN,
    input  logic [AW-1:0] UP_ADDR,
    input  logic [3:0]    UP_BE,
    input  logic [DW-1:0] UP_DI,
    output logic [DW-1:0] UP_DOUT,
    output logic          UP_STALL,
    output logic          D_MEM_CSN,
    output logic          D_MEM_WEN,
    output logic [AW-1:0] D_MEM_ADDR,
    output logic [3:0]    D_MEM_BE,
    output logic [DW-1:0] D_MEM_DOUT,
    input  logic [DW-1:0] D_MEM_DI,
    input  logic          D_MEM_RDY,
    output logic          WB_FULL,
    output logic          WB_EMPTY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_RESP} state_t;

    state_t state, nstate;

    logic [AW-1:0] addr_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic [DW-1:0] dout_q, dout, cap_val;
    logic [AW-1:0] maddr_q, maddr;
    logic [3:0]    mbe_q, mbe;
    logic [DW-1:0] mdo_q, mdo;
    logic          mcsn, mwen, stall, push, pop, cap;
    logic          full, empty, is_wr, is_rd, hit, fwd;
    logic [DW-1:0] fwd_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign is_wr = !UP_CSN && !UP_WEN;
    assign is_rd = !UP_CSN && UP_WEN;

    // Walk oldest to youngest so the last match is the youngest entry.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count &&
                addr_q[head + PW'(k)][AW-1:2] == UP_ADDR[AW-1:2])
                hit = 1'b1;
        end
    end

`ifdef WB_FWD_EN
    logic [3:0] hit_be;
    always_comb begin
        hit_be   = '0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count &&
                addr_q[head + PW'(k)][AW-1:2] == UP_ADDR[AW-1:2]) begin
                hit_be   = be_q[head + PW'(k)];
                fwd_data = data_q[head + PW'(k)];
            end
        end
    end
    assign fwd = hit && (hit_be == 4'b1111);
`else
    assign fwd      = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        nstate  = state;
        push    = 1'b0;
        pop     = 1'b0;
        stall   = 1'b0;
        cap     = 1'b0;
        cap_val = D_MEM_DI;
        dout    = dout_q;
        mcsn    = 1'b1;
        mwen    = 1'b1;
        maddr   = maddr_q;
        mbe     = mbe_q;
        mdo     = mdo_q;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    mcsn  = 1'b0;
                    mwen  = 1'b0;
                    maddr = addr_q[head];
                    mbe   = be_q[head];
                    mdo   = data_q[head];
                    pop   = D_MEM_RDY;
                end
                if (is_wr) begin
                    if (full) stall = 1'b1;
                    else      push  = 1'b1;
                end else if (is_rd) begin
                    if (fwd) begin
                        dout    = fwd_data;
                        cap     = 1'b1;
                        cap_val = fwd_data;
                    end else if (hit) begin
                        stall = 1'b1;
                    end else begin
                        stall  = 1'b1;
                        nstate = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mcsn  = 1'b0;
                mwen  = 1'b1;
                maddr = UP_ADDR;
                stall = 1'b1;
                if (D_MEM_RDY) nstate = RD_RESP;
            end
            RD_RESP: begin
                dout   = D_MEM_DI;
                cap    = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            dout_q  <= '0;
            maddr_q <= '0;
            mbe_q   <= '0;
            mdo_q   <= '0;
        end else begin
            state <= nstate;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (cap) dout_q <= cap_val;
            // Bus fields keep their last driven value while idle.
            if (!mcsn) begin
                maddr_q <= maddr;
                mbe_q   <= mbe;
                mdo_q   <= mdo;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail] <= UP_ADDR;
            be_q[tail]   <= UP_BE;
            data_q[tail] <= UP_DI;
        end
    end

    assign UP_DOUT    = dout;
    assign UP_STALL   = stall && !RST;
    assign D_MEM_CSN  = mcsn || RST;
    assign D_MEM_WEN  = mwen || RST;
    assign D_MEM_ADDR = maddr;
    assign D_MEM_BE   = mbe;
    assign D_MEM_DOUT = mdo;
    assign WB_FULL    = full;
    assign WB_EMPTY   = empty;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Testbench for dcache_write_buffer: scoreboard of expected memory writes
// plus per-scenario timing and read-data checks.
module tb_dcache_write_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        UP_CSN = 1'b1;
    logic        UP_WEN = 1'b1;
    logic [11:0] UP_ADDR = '0;
    logic [3:0]  UP_BE = '0;
    logic [31:0] UP_DI = '0;
    logic [31:0] UP_DOUT;
    logic        UP_STALL;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [11:0] D_MEM_ADDR;
    logic [3:0]  D_MEM_BE;
    logic [31:0] D_MEM_DOUT;
    logic [31:0] D_MEM_DI = '0;
    logic        D_MEM_RDY = 1'b1;
    logic        WB_FULL;
    logic        WB_EMPTY;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    logic [31:0] mem [int];

    dcache_write_buffer dut (
        .CLK(CLK), .RST(RST),
        .UP_CSN(UP_CSN), .UP_WEN(UP_WEN), .UP_ADDR(UP_ADDR),
        .UP_BE(UP_BE), .UP_DI(UP_DI), .UP_DOUT(UP_DOUT),
        .UP_STALL(UP_STALL),
        .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN),
        .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_BE(D_MEM_BE),
        .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI),
        .D_MEM_RDY(D_MEM_RDY),
        .WB_FULL(WB_FULL), .WB_EMPTY(WB_EMPTY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_rd(input int w);
        if (mem.exists(w)) return mem[w];
        return (w == 'h40) ? 32'hDEADBEEF : 32'h0;
    endfunction

    // Memory model: word array with byte enables, read data one cycle later.
    always @(posedge CLK) begin
        if (!RST && !D_MEM_CSN && D_MEM_RDY) begin
            if (D_MEM_WEN) begin
                D_MEM_DI <= mem_rd(int'(D_MEM_ADDR[11:2]));
            end else begin
                logic [31:0] cur;
                cur = mem_rd(int'(D_MEM_ADDR[11:2]));
                for (int b = 0; b < 4; b++)
                    if (D_MEM_BE[b]) cur[8*b +: 8] = D_MEM_DOUT[8*b +: 8];
                mem[int'(D_MEM_ADDR[11:2])] = cur;
            end
        end
    end

    // Scoreboard: every accepted memory write must match the oldest posted store.
    always @(negedge CLK) begin
        if (!RST && !D_MEM_CSN && !D_MEM_WEN && D_MEM_RDY) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL mem_wr_unexpected got=%h/%h/%h want=none",
                         D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                if ({D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT} !== e) begin
                    bad++;
                    $display("FAIL mem_wr got=%h/%h/%h want=%h/%h/%h",
                             D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT,
                             e.addr, e.be, e.data);
                end
            end
        end
    end

    // Drives one upstream access starting at posedge+1, returns stall count.
    task automatic access(input bit wr, input logic [11:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          output int stalls, output logic [31:0] rdata);
        UP_CSN = 1'b0;
        UP_WEN = !wr;
        UP_ADDR = a;
        UP_BE = be;
        UP_DI = d;
        stalls = 0;
        @(negedge CLK);
        while (UP_STALL && stalls < 200) begin
            stalls++;
            @(negedge CLK);
        end
        if (UP_STALL) begin
            total++;
            bad++;
            $display("FAIL access_timeout got=stall want=done addr=%h", a);
        end
        rdata = UP_DOUT;
        if (wr) exp_wr.push_back({a, be, d});
        @(posedge CLK);
        #1;
        UP_CSN = 1'b1;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (!WB_EMPTY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (WB_EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL %s got=%b want=1", nm, WB_EMPTY);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if ({D_MEM_CSN, D_MEM_WEN, UP_STALL, WB_EMPTY, WB_FULL} !== 5'b11010
            || UP_DOUT !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got=%b/%h want=11010/0",
                     {D_MEM_CSN, D_MEM_WEN, UP_STALL, WB_EMPTY, WB_FULL},
                     UP_DOUT);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [11:0] adr [3];
        adr[0] = 12'h010;
        adr[1] = 12'h014;
        adr[2] = 12'h018;
        D_MEM_RDY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                UP_CSN = 1'b0;
                UP_WEN = 1'b0;
                UP_ADDR = adr[i];
                UP_BE = 4'hF;
                UP_DI = 32'hA000_0000 + i;
            end else begin
                UP_CSN = 1'b1;
            end
            @(negedge CLK);
            if (i < 3) begin
                total++;
                if (UP_STALL !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_stall%0d got=%b want=0", i, UP_STALL);
                end
                exp_wr.push_back({adr[i], 4'hF, 32'hA000_0000 + i});
            end
            if (i > 0) begin
                total++;
                if ({D_MEM_CSN, D_MEM_WEN} !== 2'b00 ||
                    D_MEM_ADDR !== adr[i-1]) begin
                    bad++;
                    $display("FAIL b2b_drain%0d got=%b%b/%h want=00/%h", i,
                             D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, adr[i-1]);
                end
            end
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        total++;
        if (WB_EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL b2b_empty got=%b want=1", WB_EMPTY);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_full;
        int st;
        logic [31:0] rd;
        D_MEM_RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 12'h020 + 12'(4 * i), 4'hF, 32'hB000_0000 + i, st, rd);
            total++;
            if (st != 0) begin
                bad++;
                $display("FAIL full_push%0d got=%0d want=0", i, st);
            end
        end
        total++;
        if (WB_FULL !== 1'b1) begin
            bad++;
            $display("FAIL full_flag got=%b want=1", WB_FULL);
        end
        fork
            access(1'b1, 12'h030, 4'hF, 32'hB000_0004, st, rd);
            begin
                repeat (3) @(posedge CLK);
                #1;
                D_MEM_RDY = 1'b1;
            end
        join
        total++;
        if (st != 4) begin
            bad++;
            $display("FAIL full_stall got=%0d want=4", st);
        end
        wait_empty("full_drain");
    endtask

    task automatic test_read;
        int st;
        logic [31:0] rd;
        D_MEM_RDY = 1'b1;
        access(1'b0, 12'h100, 4'h0, 32'h0, st, rd);
        total++;
        if (st != 2 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_miss got=%0d/%h want=2/deadbeef", st, rd);
        end
        @(negedge CLK);
        total++;
        if (UP_DOUT !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_hold got=%h want=deadbeef", UP_DOUT);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_hazard;
        int st, want_st;
        logic [31:0] rd;
        D_MEM_RDY = 1'b0;
        access(1'b1, 12'h040, 4'hF, 32'h12345678, st, rd);
        fork
            access(1'b0, 12'h040, 4'h0, 32'h0, st, rd);
            begin
                repeat (2) @(posedge CLK);
                #1;
                D_MEM_RDY = 1'b1;
            end
        join
`ifdef WB_FWD_EN
        want_st = 0;
`else
        want_st = 5;
`endif
        total++;
        if (st != want_st || rd !== 32'h12345678) begin
            bad++;
            $display("FAIL hazard_full got=%0d/%h want=%0d/12345678",
                     st, rd, want_st);
        end
        wait_empty("hazard_drain");
        D_MEM_RDY = 1'b0;
        access(1'b1, 12'h044, 4'b0011, 32'h12345678, st, rd);
        fork
            access(1'b0, 12'h044, 4'h0, 32'h0, st, rd);
            begin
                repeat (2) @(posedge CLK);
                #1;
                D_MEM_RDY = 1'b1;
            end
        join
        total++;
        if (st != 5 || rd !== 32'h00005678) begin
            bad++;
            $display("FAIL hazard_part got=%0d/%h want=5/00005678", st, rd);
        end
        wait_empty("hazard_part_drain");
    endtask

    task automatic test_reset_mid_read;
        int st, n;
        logic [31:0] rd;
        D_MEM_RDY = 1'b0;
        access(1'b1, 12'h080, 4'hF, 32'hC0C0_0001, st, rd);
        access(1'b1, 12'h084, 4'hF, 32'hC0C0_0002, st, rd);
        UP_CSN = 1'b0;
        UP_WEN = 1'b1;
        UP_ADDR = 12'h200;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        total++;
        if ({D_MEM_CSN, D_MEM_WEN, UP_STALL} !== 3'b011 ||
            D_MEM_ADDR !== 12'h200) begin
            bad++;
            $display("FAIL rdreq_bus got=%b/%h want=011/200",
                     {D_MEM_CSN, D_MEM_WEN, UP_STALL}, D_MEM_ADDR);
        end
        #1;
        RST = 1'b1;
        exp_wr.delete();
        #1;
        total++;
        if ({WB_EMPTY, D_MEM_CSN, UP_STALL} !== 3'b110 ||
            UP_DOUT !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h want=110/0",
                     {WB_EMPTY, D_MEM_CSN, UP_STALL}, UP_DOUT);
        end
        @(posedge CLK);
        #1;
        UP_CSN = 1'b1;
        RST = 1'b0;
        D_MEM_RDY = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (!D_MEM_CSN) n++;
        end
        total++;
        if (n != 0 || WB_EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_idle got=%0d/%b want=0/1", n, WB_EMPTY);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full();
        test_read();
        test_hazard();
        test_reset_mid_read();
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", exp_wr.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
